fmc_i2c_init_sequencer: RTL and testbench

- Sequences the FMC424 I2C bring-up: walks a write table (CPLD mux select, SI5338B register loads).
- Issues one register-write transaction per entry to the byte-level I2C master through a valid/ready command port.
- Retries NACKed entries, enforces an inter-entry gap, and reports busy/done/error to the host.
- Sits between the top-level control logic and the I2C master that drives the SCL/SDA tri-state buffers.

---
 rtl/fmc_i2c_init_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_fmc_i2c_init_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// fmc_i2c_init_sequencer
//
// Purpose:
//   Walks an external write table for the FMC424 I2C bring-up (CPLD mux
//   select followed by SI5338B register loads). It issues one register-write
//   command per table entry to a byte-level I2C master. NACKed entries are
//   retried, an idle gap separates consecutive transactions, and the host
//   sees busy/done/error status.
//
// Optional feature:
//   `define FMC_I2C_SEQ_READBACK_EN to read back every ACKed write
//   (same device/register) and abort on a data mismatch. Without the macro
//   no read phase exists and cmd_rd is tied low.
//
// Ports:
//   CLK        system clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse, starts the sequence at entry 0 (IDLE only)
//   tbl_addr   table read address
//   tbl_data   table entry, valid one cycle after tbl_addr
//              [23:17] device, [16] last flag, [15:8] register, [7:0] data
//   cmd_valid  command request to the I2C master
//   cmd_ready  the I2C master accepts the command
//   cmd_dev    7-bit target device address
//   cmd_reg    target register
//   cmd_data   write data
//   cmd_rd     0 = write, 1 = read-back
//   rsp_done   one-cycle pulse, the transaction finished
//   rsp_nack   qualifies rsp_done, 1 = slave NACKed
//   rsp_rdata  read data, valid with rsp_done
//   busy       sequence in progress
//   done       sticky, sequence completed
//   error      sticky, sequence aborted
//   err_index  index of the entry that failed
// ---------------------------------------------------------------------------
module fmc_i2c_init_sequencer #(
  parameter int TBL_AW     = 6,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  output logic              cmd_rd,
  input  logic              rsp_done,
  input  logic              rsp_nack,
  input  logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index
);

  // A zero gap still spends one cycle in GAP, so the count saturates at 1.
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GAP_LEN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W   = $clog2(GAP_LEN + 1);

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);
  localparam logic [TBL_AW-1:0]  ADDR_MAX  = '1;
  localparam logic [TBL_AW-1:0]  ADDR_ONE  = TBL_AW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;
  localparam logic [2:0] S_FAIL   = 3'd7;

  logic [2:0]         state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               last_flag;
  logic               retrying;

`ifdef FMC_I2C_SEQ_READBACK_EN
  // Set while the outstanding command is the read-back of the current entry.
  logic rd_phase;
`else
  logic unused_rdata;

  assign cmd_rd       = 1'b0;
  assign unused_rdata = ^rsp_rdata;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tbl_addr  <= '0;
      cmd_valid <= 1'b0;
      cmd_dev   <= '0;
      cmd_reg   <= '0;
      cmd_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      last_flag <= 1'b0;
      retrying  <= 1'b0;
`ifdef FMC_I2C_SEQ_READBACK_EN
      cmd_rd    <= 1'b0;
      rd_phase  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            tbl_addr  <= '0;
            retry_cnt <= '0;
            retrying  <= 1'b0;
            state     <= S_FETCH;
          end
        end

        // tbl_addr is already on the bus; this cycle covers the ROM latency.
        S_FETCH: begin
          state <= S_LATCH;
        end

        // A retry also enters here: tbl_addr has not moved, so tbl_data still
        // holds the same entry and no new fetch is needed.
        S_LATCH: begin
          cmd_dev   <= tbl_data[23:17];
          last_flag <= tbl_data[16];
          cmd_reg   <= tbl_data[15:8];
          cmd_data  <= tbl_data[7:0];
          cmd_valid <= 1'b1;
`ifdef FMC_I2C_SEQ_READBACK_EN
          cmd_rd    <= 1'b0;
          rd_phase  <= 1'b0;
`endif
          state     <= S_ISSUE;
        end

        // The command stays frozen until the master takes it; responses that
        // arrive here are not for us and are ignored.
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rsp_done) begin
            if (rsp_nack) begin
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt <= retry_cnt + RETRY_ONE;
                retrying  <= 1'b1;
                gap_cnt   <= '0;
                state     <= S_GAP;
              end else begin
                err_index <= tbl_addr;
                state     <= S_FAIL;
              end
            end
`ifdef FMC_I2C_SEQ_READBACK_EN
            else if (!rd_phase) begin
              cmd_rd    <= 1'b1;
              cmd_valid <= 1'b1;
              rd_phase  <= 1'b1;
              state     <= S_ISSUE;
            end
            else if (rsp_rdata != cmd_data) begin
              err_index <= tbl_addr;
              state     <= S_FAIL;
            end
`endif
            else begin
              retry_cnt <= '0;
              retrying  <= 1'b0;
`ifdef FMC_I2C_SEQ_READBACK_EN
              rd_phase  <= 1'b0;
`endif
              // Running off the end of the table without a last flag must not
              // wrap to entry 0; it ends the sequence as an error instead.
              if (last_flag) begin
                state <= S_FINISH;
              end else if (tbl_addr == ADDR_MAX) begin
                err_index <= tbl_addr;
                state     <= S_FAIL;
              end else begin
                tbl_addr <= tbl_addr + ADDR_ONE;
                gap_cnt  <= '0;
                state    <= S_GAP;
              end
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= retrying ? S_LATCH : S_FETCH;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end

        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_FAIL: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fmc_i2c_init_sequencer
//
// Directed bench for fmc_i2c_init_sequencer. A behavioural I2C master answers
// commands with configurable ready hold-off, response latency, NACKs and
// corrupted read-back data, and logs every accepted write. The table is a
// small array read with one cycle of latency.
// ---------------------------------------------------------------------------
module tb_fmc_i2c_init_sequencer;

  localparam int TBL_AW     = 3;
  localparam int MAX_RETRY  = 3;
  localparam int GAP_CYCLES = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [TBL_AW-1:0] tbl_addr;
  logic [23:0]       tbl_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [6:0]        cmd_dev;
  logic [7:0]        cmd_reg;
  logic [7:0]        cmd_data;
  logic              cmd_rd;
  logic              rsp_done;
  logic              rsp_nack;
  logic [7:0]        rsp_rdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [TBL_AW-1:0] err_index;

  fmc_i2c_init_sequencer #(
    .TBL_AW     (TBL_AW),
    .MAX_RETRY  (MAX_RETRY),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .CLK       (clk),
    .reset     (reset),
    .start     (start),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dev   (cmd_dev),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .cmd_rd    (cmd_rd),
    .rsp_done  (rsp_done),
    .rsp_nack  (rsp_nack),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index)
  );

  // Bench configuration, written only by the stimulus block.
  logic [23:0] rom [0:7];
  int          rsp_lat;
  logic        nack_en;
  logic [7:0]  nack_reg;
  int          nack_limit;
  int          nack_base;
  logic        corrupt_en;
  logic [7:0]  corrupt_reg;
  int          hold_cycles;
  int          hold_req;
  int          force_req;

  // Master model state and logs, written only by the model block.
  int          cyc;
  int          n_log;
  int          n_rd;
  int          nacks_given;
  int          hold_ack;
  int          force_ack;
  int          ready_wait;
  int          lat;
  int          mstate;
  logic        cur_rd;
  logic [7:0]  cur_reg;
  logic [7:0]  last_wdata;
  int          last_rsp_edge;
  int          busy_fall;
  logic        prev_busy;
  logic [6:0]  log_dev  [0:127];
  logic [7:0]  log_reg  [0:127];
  logic [7:0]  log_data [0:127];
  int          log_acc  [0:127];
  int          log_prev [0:127];

  int          n_checks;
  int          n_pass;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Table read port: data follows the address registered on the previous edge.
  initial begin
    tbl_data = '0;
    forever begin
      @(negedge clk);
      tbl_data = rom[tbl_addr];
    end
  end

  // I2C master model. Edges are counted so that log_acc is the edge on which a
  // command was accepted and last_rsp_edge the edge on which rsp_done was seen.
  initial begin
    cmd_ready = 1'b0;
    rsp_done = 1'b0;
    rsp_nack = 1'b0;
    rsp_rdata = '0;
    n_log = 0;
    n_rd = 0;
    nacks_given = 0;
    hold_ack = 0;
    force_ack = 0;
    ready_wait = 0;
    lat = 0;
    mstate = 0;
    cur_rd = 1'b0;
    cur_reg = '0;
    last_wdata = '0;
    last_rsp_edge = 0;
    busy_fall = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
      rsp_done = 1'b0;
      rsp_nack = 1'b0;
      if (reset) begin
        mstate = 0;
        cmd_ready = 1'b0;
      end else begin
        case (mstate)
          0: begin
            if (force_req != force_ack) begin
              force_ack = force_req;
              rsp_done = 1'b1;
            end else if (cmd_valid) begin
              if (hold_req != hold_ack) begin
                hold_ack = hold_req;
                ready_wait = hold_cycles;
              end
              if (ready_wait > 0) begin
                ready_wait = ready_wait - 1;
              end else begin
                cmd_ready = 1'b1;
                mstate = 1;
              end
            end
          end
          1: begin
            cmd_ready = 1'b0;
            cur_rd = cmd_rd;
            cur_reg = cmd_reg;
            if (!cmd_rd) begin
              log_dev[n_log] = cmd_dev;
              log_reg[n_log] = cmd_reg;
              log_data[n_log] = cmd_data;
              log_acc[n_log] = cyc;
              log_prev[n_log] = last_rsp_edge;
              n_log = n_log + 1;
              last_wdata = cmd_data;
            end else begin
              n_rd = n_rd + 1;
            end
            lat = rsp_lat;
            mstate = 2;
          end
          default: begin
            if (lat > 1) begin
              lat = lat - 1;
            end else begin
              rsp_done = 1'b1;
              if (!cur_rd && nack_en && cur_reg == nack_reg &&
                  (nacks_given - nack_base) < nack_limit) begin
                rsp_nack = 1'b1;
                nacks_given = nacks_given + 1;
              end
              rsp_rdata = (cur_rd && corrupt_en && cur_reg == corrupt_reg) ?
                          (last_wdata ^ 8'h01) : last_wdata;
              last_rsp_edge = cyc + 1;
              mstate = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_log < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output(tag, {31'd0, n_log >= target}, 32'd1);
  endtask

  task automatic load_short_table();
    for (int i = 0; i < 8; i++) rom[i] = '0;
    rom[0] = {7'h7C, 1'b0, 8'h00, 8'h01};
    rom[1] = {7'h70, 1'b0, 8'hE6, 8'h10};
    rom[2] = {7'h70, 1'b1, 8'hF6, 8'h02};
  endtask

  initial begin
    int b;
    int bn;
    int k;
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    start = 1'b0;
    rsp_lat = 2;
    nack_en = 1'b0;
    nack_reg = '0;
    nack_limit = 0;
    nack_base = 0;
    corrupt_en = 1'b0;
    corrupt_reg = '0;
    hold_cycles = 0;
    hold_req = 0;
    force_req = 0;
    load_short_table();

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_error", {31'd0, error}, 32'd0);
    check_output("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_output("rst_cmd_rd", {31'd0, cmd_rd}, 32'd0);
    check_output("rst_tbl_addr", {29'd0, tbl_addr}, 32'd0);
    check_output("rst_err_index", {29'd0, err_index}, 32'd0);
    check_output("rst_cmd_fields", {9'd0, cmd_dev, cmd_reg, cmd_data}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] three-entry sequence, start while busy ignored");
    b = n_log;
    bn = n_rd;
    apply_stimulus();
    wait_writes("t1_first_write", b + 1, 200);
    apply_stimulus();
    wait_idle("t1_idle", 500);
    check_output("t1_nwrites", n_log - b, 3);
    check_output("t1_w0", {9'd0, log_dev[b], log_reg[b], log_data[b]}, 32'h007C_0001);
    check_output("t1_w1", {9'd0, log_dev[b+1], log_reg[b+1], log_data[b+1]}, 32'h0070_E610);
    check_output("t1_w2", {9'd0, log_dev[b+2], log_reg[b+2], log_data[b+2]}, 32'h0070_F602);
    check_output("t1_gap1", log_acc[b+1] - log_prev[b+1], 7);
    check_output("t1_gap2", log_acc[b+2] - log_prev[b+2], 7);
    check_output("t1_busy_fall", busy_fall - last_rsp_edge, 1);
    check_output("t1_done", {31'd0, done}, 32'd1);
    check_output("t1_error", {31'd0, error}, 32'd0);
`ifdef FMC_I2C_SEQ_READBACK_EN
    check_output("t1_reads", n_rd - bn, 3);
`else
    check_output("t1_no_reads", n_rd - bn, 0);
    check_output("t1_cmd_rd", {31'd0, cmd_rd}, 32'd0);
`endif

    $display("[TB] response pulse while idle");
    b = n_log;
    force_req = force_req + 1;
    repeat (4) @(negedge clk);
    check_output("idle_rsp_done", {30'd0, done, busy}, 32'd2);
    check_output("idle_rsp_nwrites", n_log - b, 0);

    $display("[TB] ready held low for 20 cycles");
    b = n_log;
    hold_cycles = 20;
    hold_req = hold_req + 1;
    apply_stimulus();
    k = 0;
    while (!cmd_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      check_output($sformatf("hold_%0d", i),
                   {8'd0, cmd_valid, cmd_dev, cmd_reg, cmd_data}, 32'h00FC_0001);
      @(negedge clk);
    end
    wait_idle("t2_idle", 500);
    check_output("t2_nwrites", n_log - b, 3);
    check_output("t2_second_is_e1", {24'd0, log_reg[b+1]}, 32'h0000_00E6);

    $display("[TB] entry 1 NACKs twice then ACKs");
    b = n_log;
    nack_base = nacks_given;
    nack_en = 1'b1;
    nack_reg = 8'hE6;
    nack_limit = 2;
    apply_stimulus();
    wait_idle("t3_idle", 800);
    check_output("t3_nwrites", n_log - b, 5);
    check_output("t3_retries", {log_reg[b+1], log_reg[b+2], log_reg[b+3], log_reg[b+4]},
                 32'hE6E6_E6F6);
    check_output("t3_retry_gap", log_acc[b+2] - log_prev[b+2], 6);
    check_output("t3_status", {30'd0, done, error}, 32'd2);

    $display("[TB] entry 1 always NACKs");
    b = n_log;
    nack_base = nacks_given;
    nack_limit = 99;
    apply_stimulus();
    wait_idle("t4_idle", 800);
    check_output("t4_nwrites", n_log - b, 5);
    check_output("t4_last_is_e1", {24'd0, log_reg[b+4]}, 32'h0000_00E6);
    check_output("t4_status", {30'd0, done, error}, 32'd1);
    check_output("t4_err_index", {29'd0, err_index}, 32'd1);

    $display("[TB] reset while waiting on entry 1");
    nack_en = 1'b0;
    rsp_lat = 6;
    b = n_log;
    apply_stimulus();
    wait_writes("t5_reach_e1", b + 2, 200);
    reset = 1'b1;
    #1;
    check_output("t5_rst_outs", {28'd0, busy, cmd_valid, done, error}, 32'd0);
    check_output("t5_rst_addr", {29'd0, tbl_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_lat = 2;
    @(negedge clk);
    b = n_log;
    apply_stimulus();
    wait_idle("t5_idle", 500);
    check_output("t5_nwrites", n_log - b, 3);
    check_output("t5_replay_e0", {24'd0, log_reg[b]}, 32'd0);
    check_output("t5_done", {31'd0, done}, 32'd1);

    $display("[TB] table end without last flag");
    for (int i = 0; i < 8; i++) rom[i] = {7'h50, 1'b0, 8'h20 + 8'(i), 8'(i)};
    b = n_log;
    apply_stimulus();
    wait_idle("t6_idle", 2000);
    check_output("t6_nwrites", n_log - b, 8);
    check_output("t6_last_reg", {24'd0, log_reg[b+7]}, 32'h0000_0027);
    check_output("t6_status", {30'd0, done, error}, 32'd1);
    check_output("t6_err_index", {29'd0, err_index}, 32'd7);

`ifdef FMC_I2C_SEQ_READBACK_EN
    $display("[TB] read-back mismatch on entry 1");
    load_short_table();
    corrupt_en = 1'b1;
    corrupt_reg = 8'hE6;
    b = n_log;
    bn = n_rd;
    apply_stimulus();
    wait_idle("rb_bad_idle", 800);
    check_output("rb_bad_counts", ((n_log - b) << 8) | (n_rd - bn), 32'h0000_0202);
    check_output("rb_bad_status", {30'd0, done, error}, 32'd1);
    check_output("rb_bad_err_index", {29'd0, err_index}, 32'd1);
    corrupt_en = 1'b0;
    b = n_log;
    bn = n_rd;
    apply_stimulus();
    wait_idle("rb_ok_idle", 800);
    check_output("rb_ok_counts", ((n_log - b) << 8) | (n_rd - bn), 32'h0000_0303);
    check_output("rb_ok_status", {30'd0, done, error}, 32'd2);
`endif

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
